// File: rtl/gf_mul_pkg.sv
// Shared types and constants for the digit-serial GF(2^m) multiplier.
package gf_mul_pkg;

  // Controller states: waiting for operands, stepping digits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reduction polynomial of sect163 without the x^163 term.
  localparam logic [162:0] GF163_G = 163'hC9;

  // Number of DIGITAL-bit digits needed to cover a DATA_WIDTH-bit multiplier.
  function automatic int num_digits(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/gf_mul_digit_ctrl_serial.sv
// Digit-step block: t_i_j = t_i1_j1 * x^DIGITAL + a * digit(b), reduced mod f.
// The digit is consumed MSB-first, one Horner step per bit.
module serial #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] g,
  input  logic [DIGITAL-1:0]    b,
  input  logic [DATA_WIDTH-1:0] t_i1_j1,
  output logic [DATA_WIDTH-1:0] t_i_j
);

  logic [DATA_WIDTH-1:0] acc;

  // Multiply by x with reduction, then conditionally add a, for each digit bit.
  always_comb begin
    acc = t_i1_j1;
    for (int i = DIGITAL - 1; i >= 0; i--) begin
      acc = {acc[DATA_WIDTH-2:0], 1'b0} ^ ({DATA_WIDTH{acc[DATA_WIDTH-1]}} & g);
      if (b[i]) begin
        acc = acc ^ a;
      end
    end
    t_i_j = acc;
  end

endmodule

// File: rtl/gf_mul_digit_ctrl.sv
// Sequential wrapper around the digit-step block: one GF(2^m) product per
// transaction, b fed MSB-first DIGITAL bits per cycle, one operation in flight.
module gf_mul_digit_ctrl
  import gf_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] g,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] c
);

  localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGITAL);
  localparam int BW         = NUM_DIGITS * DIGITAL;
  localparam int CW         = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] g_r;
  logic [DATA_WIDTH-1:0] t;
  logic [DATA_WIDTH-1:0] t_nxt;
  logic [BW-1:0]         b_sh;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  last;

  serial #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIGITAL    (DIGITAL)
  ) u_serial (
    .a       (a_r),
    .g       (g_r),
    .b       (b_sh[BW-1 -: DIGITAL]),
    .t_i1_j1 (t),
    .t_i_j   (t_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        last = (cnt == LAST);
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit stepping, result capture and output handshake.
  // The zero pad sits above b so the leading digits contribute nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      g_r       <= '0;
      b_sh      <= '0;
      t         <= '0;
      cnt       <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_r  <= a;
        g_r  <= g;
        b_sh <= BW'(b);
        t    <= '0;
        cnt  <= '0;
      end
      if (state == RUN) begin
        t    <= t_nxt;
        b_sh <= b_sh << DIGITAL;
        cnt  <= cnt + CW'(1);
      end
      if (last) begin
        c         <= t_nxt;
        out_valid <= 1'b1;
      end
      if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gf_mul_digit_ctrl.md
Name: gf_mul_digit_ctrl

Overview:
- Sequential wrapper that drives the combinational digit-step block `serial` and delivers one GF(2^m) product c = a·b mod f(x) per transaction.
- Sits directly upstream of `serial`:
  - registers operands a, g and b;
  - presents b MSB-first, DIGITAL bits per cycle;
  - feeds the previous accumulator back in as t_i1_j1;
  - captures t_i_j.
- valid/ready handshakes on both sides; one multiplication in flight.

Parameters:
- DATA_WIDTH, 163, field degree m; operand and result width.
- DIGITAL, 4, bits of b consumed per cycle (≥1).
- NUM_DIGITS, ceil(DATA_WIDTH/DIGITAL), derived localparam (41 at defaults); cycles per product.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- a  in  DATA_WIDTH  multiplicand.
- b  in  DATA_WIDTH  multiplier (digit-serialised internally).
- g  in  DATA_WIDTH  f(x) without the x^m term (sect163: 0xC9).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- c  out  DATA_WIDTH  product a·b mod f.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, c=0;
  - accumulator, counter and operand registers = 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and g.
  - Latch b_sh = {zero-pad, b} of width NUM_DIGITS·DIGITAL; pad is at the MSB side so leading zero digits contribute nothing.
  - Set t=0, cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the top DIGITAL bits of b_sh drive serial.b.
  - t <= serial.t_i_j, with serial.t_i1_j1=t.
  - b_sh shifts left by DIGITAL; cnt++.
  - When cnt==NUM_DIGITS-1, that edge performs the final update: c <= serial.t_i_j, out_valid<=1, go to DONE.
- Latency: out_valid is first high after the NUM_DIGITS-th rising edge following the accepting edge (41 at defaults).
- DONE:
  - out_valid=1; c stable.
  - in_ready=0, so no overlap with the next operation.
  - On out_ready: out_valid<=0, go to IDLE. in_ready rises in the following cycle; there is no same-cycle pass-through.
- out_ready while out_valid=0: ignored.
- in_valid outside IDLE: ignored; upstream must hold its operands until in_ready.
- The a, b and g inputs are don't-care except on the accepting edge.
- Arithmetic is entirely carry-less (XOR). c is always reduced, degree < DATA_WIDTH, provided g has degree < DATA_WIDTH.
- rst_n asserted mid-RUN or mid-DONE: immediate return to the reset state; the partial result is discarded; out_valid never glitches high.
- Counter width: $clog2(NUM_DIGITS+1). No wrap occurs because cnt is cleared on accept.
- NUM_DIGITS==1 (DIGITAL≥DATA_WIDTH): RUN lasts exactly one cycle.

Decomposition:
- Package gf_mul_pkg:
  - the state enum {IDLE, RUN, DONE};
  - a function computing NUM_DIGITS;
  - constant GF163_G = 163'hC9.
- Exactly one sub-module: the existing digit-step block `serial`, instantiated once with DATA_WIDTH and DIGITAL passed through.
- The FSM, counter, shift register and accumulator stay in this module.

Test Plan:
- Identity. a=1, b=1, g=0xC9, defaults; out_ready=1.
  - Expect c=1.
  - Expect out_valid exactly 41 edges after accept.
  - Expect in_ready=0 throughout RUN/DONE.
- Reduction. a=2 (x), b=1<<162, g=0xC9.
  - Expect c=0xC9, since x^163 ≡ x^7+x^6+x^3+1.
- Non-divisible padding. DATA_WIDTH=8, DIGITAL=3, g=0x1B, a=0x57, b=0x83.
  - Expect c=0xC1.
  - Expect 3-cycle latency.
- Backpressure. Hold out_ready=0 for 10 cycles after out_valid.
  - c and out_valid stay constant.
  - in_valid pulses are ignored.
  - Release: out_valid drops, then in_ready rises next cycle.
- Back-to-back.
  - Run 1000 random (a,b) pairs with in_valid always high and random out_ready.
  - Every c matches a bitwise shift-and-add reference model.
  - Zero operands give c=0.
- Reset mid-operation. Assert rst_n=0 at RUN cycle 20.
  - Outputs are at their reset values asynchronously.
  - After release, a fresh a=3, b=3 gives c=5.
